// File: rtl/snake_if.sv
// Snake controller display/keyboard bundle: keycode and segment address in, segment/food/status out.
// Plain wires with no handshake; the segment read is combinational, everything else comes from registers.
interface snake_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int IW = $clog2(MAX_LEN);

    logic [7:0]    keycode;
    logic [IW-1:0] seg_idx;
    logic [9:0]    seg_x;
    logic [9:0]    seg_y;
    logic          seg_valid;
    logic [IW:0]   length;
    logic [9:0]    FoodX;
    logic [9:0]    FoodY;
    logic [7:0]    score;
    logic          game_over;

    modport master (
        output keycode, seg_idx,
        input  seg_x, seg_y, seg_valid, length, FoodX, FoodY, score, game_over
    );

    modport slave (
        input  keycode, seg_idx,
        output seg_x, seg_y, seg_valid, length, FoodX, FoodY, score, game_over
    );
endinterface

// File: rtl/snake_body_ctrl.sv
// Grid snake: steering, wall/self collision, growth on food, LFSR food relocation; one move per STEP_DIV frames.
// Segment read is combinational; all other outputs are registered and update one frame after their cause.
module snake_body_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 2,
    parameter int CELL     = 16,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int STEP_DIV = 8
) (
    input  logic     frame_clk,
    input  logic     Reset,
    snake_if.slave   bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;
    localparam int CS = $clog2(CELL);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [7:0]    KEY_ENTER = 8'h28;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PLACE, S_OVER} state_t;
    typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            D_RIGHT: return D_LEFT;
            D_LEFT:  return D_RIGHT;
            D_UP:    return D_DOWN;
            default: return D_UP;
        endcase
    endfunction

    state_t        state_q;
    dir_t          dir_q, pend_dir_q;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [LW-1:0] len_q;
    logic [XW-1:0] food_x_q;
    logic [YW-1:0] food_y_q;
    logic [7:0]    score_q;
    logic          game_over_q;
    logic [SW-1:0] step_q;
    logic [15:0]   lfsr_q;

    logic [15:0]   lfsr_d;
    logic          key_vld, steer_ok, move, do_init;
    dir_t          key_dir, ref_dir;
    logic [XW-1:0] nx_x, cand_x;
    logic [YW-1:0] nx_y, cand_y;
    logic          off_grid, eat, self_hit, cand_hit;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand_x = XW'(32'(lfsr_q[15:8]) % GRID_W);
    assign cand_y = YW'(32'(lfsr_q[7:0]) % GRID_H);
    assign move   = ((state_q == S_RUN) || (state_q == S_PLACE)) && (step_q == STEP_LAST);
    assign do_init = Reset || ((state_q == S_OVER) && (bus.keycode == KEY_ENTER));

    // On a move frame dir is about to become pend_dir, so a key is judged against that.
    assign ref_dir  = move ? pend_dir_q : dir_q;
    assign steer_ok = key_vld && (key_dir != opposite(ref_dir));

    always_comb begin
        key_vld = 1'b1;
        key_dir = D_RIGHT;
        case (bus.keycode)
            8'h04:   key_dir = D_LEFT;
            8'h07:   key_dir = D_RIGHT;
            8'h16:   key_dir = D_DOWN;
            8'h1A:   key_dir = D_UP;
            default: key_vld = 1'b0;
        endcase
    end

    always_comb begin
        nx_x     = seg_x_q[0];
        nx_y     = seg_y_q[0];
        off_grid = 1'b0;
        case (pend_dir_q)
            D_RIGHT: if (seg_x_q[0] == XW'(GRID_W - 1)) off_grid = 1'b1; else nx_x = seg_x_q[0] + 1'b1;
            D_LEFT:  if (seg_x_q[0] == '0)              off_grid = 1'b1; else nx_x = seg_x_q[0] - 1'b1;
            D_UP:    if (seg_y_q[0] == '0)              off_grid = 1'b1; else nx_y = seg_y_q[0] - 1'b1;
            default: if (seg_y_q[0] == YW'(GRID_H - 1)) off_grid = 1'b1; else nx_y = seg_y_q[0] + 1'b1;
        endcase
        // Food is stale while a new spot is being searched, so eating only counts in RUN.
        eat      = (state_q == S_RUN) && (nx_x == food_x_q) && (nx_y == food_y_q);
        self_hit = 1'b0;
        cand_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((eat ? (LW'(i) < len_q) : (LW'(i + 1) < len_q)) &&
                (seg_x_q[i] == nx_x) && (seg_y_q[i] == nx_y))
                self_hit = 1'b1;
            if ((LW'(i) < len_q) && (seg_x_q[i] == cand_x) && (seg_y_q[i] == cand_y))
                cand_hit = 1'b1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (do_init) begin
            state_q     <= S_IDLE;
            dir_q       <= D_RIGHT;
            pend_dir_q  <= D_RIGHT;
            len_q       <= LW'(INIT_LEN);
            food_x_q    <= XW'(3 * GRID_W / 4);
            food_y_q    <= YW'(GRID_H / 2);
            game_over_q <= 1'b0;
            step_q      <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
                seg_y_q[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
            end
            // Restart keeps the score and the random sequence; only a real reset clears them.
            if (Reset) begin
                lfsr_q  <= 16'hACE1;
                score_q <= '0;
            end else begin
                lfsr_q  <= lfsr_d;
            end
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                S_IDLE: begin
                    if (steer_ok) begin
                        pend_dir_q <= key_dir;
                        state_q    <= S_RUN;
                        step_q     <= '0;
                    end
                end
                S_RUN, S_PLACE: begin
                    if (steer_ok) pend_dir_q <= key_dir;
                    if ((state_q == S_PLACE) && !cand_hit) begin
                        food_x_q <= cand_x;
                        food_y_q <= cand_y;
                        state_q  <= S_RUN;
                    end
                    if (move) begin
                        step_q <= '0;
                        dir_q  <= pend_dir_q;
                        if (off_grid || self_hit) begin
                            state_q     <= S_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg_x_q[i] <= seg_x_q[i - 1];
                                seg_y_q[i] <= seg_y_q[i - 1];
                            end
                            seg_x_q[0] <= nx_x;
                            seg_y_q[0] <= nx_y;
                            if (eat) begin
                                if (len_q != LW'(MAX_LEN)) len_q <= len_q + 1'b1;
                                if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                                state_q <= S_PLACE;
                            end
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.seg_x     = 10'(seg_x_q[bus.seg_idx]) << CS;
    assign bus.seg_y     = 10'(seg_y_q[bus.seg_idx]) << CS;
    assign bus.seg_valid = (LW'(bus.seg_idx) < len_q);
    assign bus.length    = len_q;
    assign bus.FoodX     = 10'(food_x_q) << CS;
    assign bus.FoodY     = 10'(food_y_q) << CS;
    assign bus.score     = score_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl: reset layout, stepping, growth, placement, wall/self collision, restart.
module tb_snake_body_ctrl;
    localparam int STEP = 8;
    localparam int GW   = 40;
    localparam int GH   = 30;
    localparam int DR = 0, DL = 1, DU = 2, DD = 3;
    localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_S = 8'h16, K_W = 8'h1A, K_ENT = 8'h28;

    logic frame_clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cur_dir;

    snake_if #(.MAX_LEN(16)) bus ();

    snake_body_ctrl #(
        .MAX_LEN(16), .INIT_LEN(2), .CELL(16), .GRID_W(GW), .GRID_H(GH), .STEP_DIV(STEP)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (rst),
        .bus       (bus)
    );

    always #10 frame_clk = ~frame_clk;

    initial begin
        #(20 * 20000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    // One key press followed by the rest of the step period; ends just after the next move edge.
    task automatic move_key(input logic [7:0] k);
        bus.keycode = k;
        frames(1);
        bus.keycode = 8'h00;
        frames(STEP - 1);
    endtask

    task automatic rd_px(input int idx, output int px, output int py);
        bus.seg_idx = 4'(idx);
        #1;
        px = int'(bus.seg_x);
        py = int'(bus.seg_y);
    endtask

    task automatic rd_cell(input int idx, output int cx, output int cy);
        int px, py;
        rd_px(idx, px, py);
        cx = px / 16;
        cy = py / 16;
    endtask

    function automatic logic [7:0] keyof(input int d);
        case (d)
            DR:      return K_D;
            DL:      return K_A;
            DU:      return K_W;
            default: return K_S;
        endcase
    endfunction

    function automatic int opp(input int d);
        case (d)
            DR:      return DL;
            DL:      return DR;
            DU:      return DD;
            default: return DU;
        endcase
    endfunction

    task automatic chk_layout(input string tag, input int exp_score);
        int px, py;
        chk({tag, "_len"}, bus.length, 2);
        rd_px(0, px, py);
        chk({tag, "_h_x"}, px, 320);
        chk({tag, "_h_y"}, py, 240);
        rd_px(1, px, py);
        chk({tag, "_s1_x"}, px, 304);
        chk({tag, "_s1_y"}, py, 240);
        chk({tag, "_food_x"}, bus.FoodX, 480);
        chk({tag, "_food_y"}, bus.FoodY, 240);
        chk({tag, "_score"}, bus.score, exp_score);
        chk({tag, "_over"}, bus.game_over, 0);
    endtask

    // Greedy walk toward the food; with at most four segments the head cannot reach its own body.
    task automatic nav_to_len(input int target);
        int hx, hy, fx, fy, nd;
        for (int n = 0; n < 300 && int'(bus.length) < target; n++) begin
            rd_cell(0, hx, hy);
            fx = int'(bus.FoodX) / 16;
            fy = int'(bus.FoodY) / 16;
            if (fx > hx && cur_dir != DL)      nd = DR;
            else if (fx < hx && cur_dir != DR) nd = DL;
            else if (fy > hy && cur_dir != DU) nd = DD;
            else if (fy < hy && cur_dir != DD) nd = DU;
            else if (cur_dir == DR || cur_dir == DL) nd = (hy < GH / 2) ? DD : DU;
            else nd = (hx < GW / 2) ? DR : DL;
            cur_dir = nd;
            move_key(keyof(nd));
        end
        chk("nav_len", bus.length, target);
    endtask

    // Three turns in one rotation bring the head back beside its start: onto index 3.
    task automatic square(output int ex, output int ey, output int px2, output int py2);
        int hx, hy, h, v, hs, vs;
        rd_cell(0, hx, hy);
        if (cur_dir == DU || cur_dir == DD) begin
            h = (hx < GW / 2) ? DR : DL;
            cur_dir = h;
            move_key(keyof(h));
            rd_cell(0, hx, hy);
        end else begin
            h = cur_dir;
        end
        v  = (hy < GH / 2) ? DD : DU;
        hs = (h == DR) ? 1 : -1;
        vs = (v == DD) ? 1 : -1;
        move_key(keyof(v));
        move_key(keyof(opp(h)));
        move_key(keyof(opp(v)));
        cur_dir = opp(v);
        ex  = hx - hs;
        ey  = hy;
        px2 = hx - hs;
        py2 = hy + vs;
    endtask

    initial begin
        int px, py, fx, fy, hits, placed, ex, ey, x2, y2;
        rst = 1'b1;
        bus.keycode = 8'h00;
        bus.seg_idx = '0;
        frames(2);
        rst = 1'b0;

        // 1: reset layout, stationary in IDLE, A ignored
        chk_layout("rst", 0);
        bus.seg_idx = 4'd1;
        #1 chk("valid1", bus.seg_valid, 1);
        bus.seg_idx = 4'd2;
        #1 chk("valid2", bus.seg_valid, 0);
        frames(20);
        rd_px(0, px, py);
        chk("idle_hx", px, 320);
        bus.keycode = K_A;
        frames(1);
        bus.keycode = 8'h00;
        frames(10);
        rd_px(0, px, py);
        chk("idle_a_hx", px, 320);

        // 2: start right, one cell per STEP frames, A reversal ignored
        bus.keycode = K_D;
        frames(1);
        bus.keycode = 8'h00;
        frames(STEP - 1);
        rd_px(0, px, py);
        chk("pre_move_hx", px, 320);
        frames(1);
        rd_px(0, px, py);
        chk("mv1_hx", px, 336);
        chk("mv1_hy", py, 240);
        rd_px(1, px, py);
        chk("mv1_s1x", px, 320);
        move_key(K_A);
        rd_px(0, px, py);
        chk("mv2_hx", px, 352);
        chk("mv2_hy", py, 240);
        cur_dir = DR;

        // 3: eat at cell (30,15), grow, relocate food off the body
        for (int i = 0; i < 7; i++) move_key(K_D);
        chk("pre_eat_len", bus.length, 2);
        move_key(K_D);
        chk("eat_len", bus.length, 3);
        chk("eat_score", bus.score, 1);
        rd_px(0, px, py);
        chk("eat_hx", px, 480);
        rd_px(2, px, py);
        chk("eat_s2x", px, 448);
        chk("eat_over", bus.game_over, 0);
        placed = 0;
        for (int k = 0; k < STEP - 1; k++) begin
            frames(1);
            if (placed == 0 && (bus.FoodX != 10'd480 || bus.FoodY != 10'd240)) begin
                placed = 1;
                fx = int'(bus.FoodX);
                fy = int'(bus.FoodY);
                hits = 0;
                for (int i = 0; i < 3; i++) begin
                    rd_px(i, px, py);
                    if (px == fx && py == fy) hits++;
                end
                chk("food_free", hits, 0);
                chk("food_in_grid", (fx < 640 && fy < 480) ? 1 : 0, 1);
            end
        end
        chk("place_done", placed, 1);
        frames(1);

        // 5: tail-vacating square at length 4 is safe; the same at length 5 is a self hit
        nav_to_len(4);
        square(ex, ey, x2, y2);
        chk("tailvac_over", bus.game_over, 0);
        rd_cell(0, px, py);
        chk("tailvac_hx", px, ex);
        chk("tailvac_hy", py, ey);
        nav_to_len(5);
        square(ex, ey, x2, y2);
        chk("self_over", bus.game_over, 1);
        chk("self_len", bus.length, 5);
        chk("self_score", bus.score, 3);
        frames(24);
        rd_cell(0, px, py);
        chk("self_frz_hx", px, x2);
        chk("self_frz_hy", py, y2);
        bus.keycode = K_ENT;
        frames(1);
        bus.keycode = 8'h00;
        chk_layout("restart1", 3);

        // 4: up to row 0, then the wall
        bus.keycode = K_D;
        frames(1);
        bus.keycode = K_W;
        frames(1);
        bus.keycode = 8'h00;
        frames(STEP - 1);
        rd_px(0, px, py);
        chk("up1_hx", px, 320);
        chk("up1_hy", py, 224);
        for (int i = 0; i < 14; i++) move_key(8'h00);
        rd_px(0, px, py);
        chk("row0_hy", py, 0);
        chk("row0_over", bus.game_over, 0);
        move_key(8'h00);
        chk("wall_over", bus.game_over, 1);
        frames(16);
        rd_px(0, px, py);
        chk("wall_frz_hx", px, 320);
        chk("wall_frz_hy", py, 0);
        rd_px(1, px, py);
        chk("wall_frz_s1y", py, 16);
        bus.keycode = K_ENT;
        frames(1);
        bus.keycode = 8'h00;
        chk_layout("restart2", 3);

        // 6: reset during OVER and during PLACE
        bus.keycode = K_W;
        frames(1);
        bus.keycode = 8'h00;
        frames(16 * STEP);
        chk("r_over_pre", bus.game_over, 1);
        rst = 1'b1;
        frames(1);
        rst = 1'b0;
        chk_layout("rst_over", 0);
        bus.keycode = K_D;
        frames(1);
        bus.keycode = 8'h00;
        frames(10 * STEP);
        chk("r_place_len", bus.length, 3);
        bus.keycode = K_D;
        rst = 1'b1;
        frames(1);
        rst = 1'b0;
        bus.keycode = 8'h00;
        chk_layout("rst_place", 0);
        frames(12);
        rd_px(0, px, py);
        chk("rst_idle_hx", px, 320);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
